btb_upd_sched: RTL and testbench
================================

// Module: btb_upd_sched
// PURPOSE
//   Sequences all writes into the 128-entry branch target buffer (BTB) table.
//   Queues resolved-branch updates from ID and drains them into the table's
//   single write port. Arbitrates that port against IF-stage lookups.
//   Runs a full-table invalidate sweep after reset and on request.
// PARAMETERS
//   IDX_W      7   BTB index width; the table holds 2**IDX_W entries
//   PC_W       32  target address width
//   DEPTH      4   update queue depth (power of 2, >=2)
//   STARVE_MAX 8   cycles a queued head may wait before a forced drain
// PORTS
//   clk         in   1          rising-edge clock
//   rst_n       in   1          synchronous reset, active low
//   upd_valid   in   1          ID offers a resolved branch update
//   upd_ready   out  1          queue can accept an update this cycle
//   upd_idx     in   IDX_W      BTB index of the resolved branch
//   upd_target  in   PC_W       resolved target (pc_offset / pc_offset_j / pc+4)
//   upd_taken   in   1          branch was taken (counter increments, else decrements)
//   upd_mispred in   1          prediction was wrong; target field must be rewritten
//   inv_all     in   1          request a full-table invalidate
//   lookup_req  in   1          IF wants the table read port this cycle
//   lookup_gnt  out  1          IF lookup granted; low means IF holds its pc
//   tbl_we      out  1          table write strobe
//   tbl_idx     out  IDX_W      table write index
//   tbl_target  out  PC_W       table write target
//   tbl_taken   out  1          counter direction for the written entry
//   tbl_tgt_we  out  1          rewrite the target field (mispredict or clear)
//   tbl_clr     out  1          invalidate the entry (target = all-ones, ctr = 2'b11)
//   busy        out  1          sweep in progress
//   q_count     out  $clog2(DEPTH)+1  current queue occupancy
// BEHAVIOUR
// - States: INIT, RUN, CLEAR. Reset enters INIT with the sweep counter at 0 and
//   the queue empty.
// - Reset values: upd_ready=0, lookup_gnt=0, tbl_*=0, busy=1, q_count=0.
// - INIT/CLEAR sweep:
//   - each cycle: tbl_we=1, tbl_clr=1, tbl_tgt_we=1, tbl_idx=sweep counter.
//   - after the write at index 2**IDX_W-1, the next state is RUN. The sweep
//     takes exactly 2**IDX_W cycles.
//   - during the sweep: busy=1, upd_ready=0, lookup_gnt=0.
//   - inv_all during a sweep restarts the counter at 0.
// - RUN queue:
//   - upd_ready = (q_count<DEPTH). No same-cycle push at full, even when a pop
//     occurs in that cycle.
//   - push on upd_valid&&upd_ready.
//   - merge: if the queue is non-empty and upd_idx equals the tail entry's
//     index, the new update overwrites the tail and q_count is unchanged.
//     The mispred flags are ORed.
// - RUN drain (pop head) when q_count>0 and any of:
//   - !lookup_req
//   - q_count==DEPTH
//   - the head has waited STARVE_MAX cycles
// - Drain outputs: tbl_we=1, tbl_idx/target/taken from the head,
//   tbl_tgt_we=head mispred, tbl_clr=0.
// - lookup_gnt = lookup_req && !drain in RUN.
// - The tbl_* outputs and lookup_gnt are combinational from registered state.
// - Update latency: an update accepted at cycle N is written no earlier than
//   N+1, and no later than N+DEPTH*STARVE_MAX.
// - Starvation counter:
//   - resets to 0 on each pop and whenever the queue is empty.
//   - increments each cycle the head is blocked.
// - Simultaneous push and pop: both occur, and q_count is unchanged.
// - inv_all in RUN:
//   - the queue is flushed and pending updates are discarded.
//   - the next state is CLEAR with the counter at 0.
//   - an upd_valid in the same cycle is dropped, and upd_ready=0 that cycle.
// - rst_n low in any state, mid-sweep or mid-drain: immediate return to INIT
//   at the next edge, and queue contents are lost.
// TESTING
// - Reset release: tbl_clr=1 with tbl_idx 0..127 on consecutive cycles, then
//   busy=0 at cycle 128 and upd_ready=1.
// - lookup_req=0; push idx=5, tgt=0x40, taken=1, mispred=1 -> next cycle
//   tbl_we=1, tbl_idx=5, tbl_tgt_we=1, q_count returns to 0.
// - lookup_req=1 held; push 4 distinct updates -> q_count=4, upd_ready=0;
//   next cycle a forced drain with lookup_gnt=0.
// - lookup_req=1; a single queued update -> drained at STARVE_MAX+1 cycles;
//   lookup_gnt=0 only on that cycle.
// - Two back-to-back pushes to idx=9 (mispred 1 then 0) -> q_count=1,
//   one write with tbl_tgt_we=1 and the second target.
// - 3 queued updates, then inv_all -> no queued write appears;
//   a 128-cycle clear sweep follows; rst_n low mid-sweep -> sweep restarts at idx 0.

Source files
------------

// File: rtl/btb_upd_sched.sv
// btb_upd_sched -- write-port scheduler for the branch target buffer.
//   Buffers resolved-branch updates from ID in a small queue (merging repeat
//   updates to the same index at the tail) and drains them into the table's
//   single write port, sharing that port with IF lookups. After reset, and
//   on inv_all, it sweeps every table entry with an invalidate write.
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   upd_*_i / upd_ready_o     resolved-branch update handshake from ID
//   inv_all_i                 full-table invalidate request
//   lookup_req_i/lookup_gnt_o IF lookup arbitration
//   tbl_*_o                   table write port
//   busy_o                    invalidate sweep in progress
//   q_count_o                 queue occupancy
module btb_upd_sched #(
    parameter int IDX_W      = 7,
    parameter int PC_W       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     upd_valid_i,
    output logic                     upd_ready_o,
    input  logic [IDX_W-1:0]         upd_idx_i,
    input  logic [PC_W-1:0]          upd_target_i,
    input  logic                     upd_taken_i,
    input  logic                     upd_mispred_i,
    input  logic                     inv_all_i,
    input  logic                     lookup_req_i,
    output logic                     lookup_gnt_o,
    output logic                     tbl_we_o,
    output logic [IDX_W-1:0]         tbl_idx_o,
    output logic [PC_W-1:0]          tbl_target_o,
    output logic                     tbl_taken_o,
    output logic                     tbl_tgt_we_o,
    output logic                     tbl_clr_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   q_count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_CLEAR = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  swp_q, swp_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ST_W-1:0]   starve_q, starve_d;

    logic [IDX_W-1:0]  q_idx_q     [DEPTH];
    logic [PC_W-1:0]   q_tgt_q     [DEPTH];
    logic              q_taken_q   [DEPTH];
    logic              q_mispred_q [DEPTH];

    logic              run, empty, full, starved, acc, push, pop, merge;
    logic [PTR_W-1:0]  tail_ptr, wr_ptr;

    assign run      = (state_q == S_RUN);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign starved  = (starve_q >= ST_W'(STARVE_MAX));
    // An invalidate request in RUN blocks both the drain and the accept.
    assign acc      = run && !inv_all_i && !full;
    assign push     = upd_valid_i && acc;
    assign pop      = run && !inv_all_i && !empty && (!lookup_req_i || full || starved);
    assign tail_ptr = head_q + PTR_W'(count_q - CNT_W'(1));
    assign wr_ptr   = head_q + PTR_W'(count_q);
    // Never merge into an entry that is leaving the queue this cycle, or the
    // newer update would be lost; it becomes a fresh entry instead.
    assign merge    = push && !empty && (q_idx_q[tail_ptr] == upd_idx_i)
                      && !(pop && count_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            swp_q   <= '0;
        end else begin
            state_q <= state_d;
            swp_q   <= swp_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        swp_d   = swp_q;
        case (state_q)
            S_INIT, S_CLEAR: begin
                if (inv_all_i) begin
                    swp_d = '0;
                end else begin
                    swp_d = swp_q + IDX_W'(1);
                    if (swp_q == '1) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (inv_all_i) begin
                    state_d = S_CLEAR;
                    swp_d   = '0;
                end
            end
            default: begin
                state_d = S_INIT;
                swp_d   = '0;
            end
        endcase
    end

    // Queue pointers and starvation counter
    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(push && !merge) - CNT_W'(pop);
        if (empty || pop)
            starve_d = '0;
        else if (!starved)
            starve_d = starve_q + ST_W'(1);
        else
            starve_d = starve_q;
        if (run && inv_all_i) begin
            head_d   = '0;
            count_d  = '0;
            starve_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= head_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Payload storage needs no reset; occupancy decides validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            if (merge) begin
                q_tgt_q[tail_ptr]     <= upd_target_i;
                q_taken_q[tail_ptr]   <= upd_taken_i;
                q_mispred_q[tail_ptr] <= q_mispred_q[tail_ptr] | upd_mispred_i;
            end else begin
                q_idx_q[wr_ptr]     <= upd_idx_i;
                q_tgt_q[wr_ptr]     <= upd_target_i;
                q_taken_q[wr_ptr]   <= upd_taken_i;
                q_mispred_q[wr_ptr] <= upd_mispred_i;
            end
        end
    end

    // Output logic; all outputs idle while reset is held.
    always_comb begin
        upd_ready_o  = 1'b0;
        lookup_gnt_o = 1'b0;
        tbl_we_o     = 1'b0;
        tbl_idx_o    = '0;
        tbl_target_o = '0;
        tbl_taken_o  = 1'b0;
        tbl_tgt_we_o = 1'b0;
        tbl_clr_o    = 1'b0;
        busy_o       = 1'b1;
        q_count_o    = count_q;
        if (rst_ni) begin
            if (run) begin
                busy_o       = 1'b0;
                upd_ready_o  = acc;
                lookup_gnt_o = lookup_req_i && !pop;
                if (pop) begin
                    tbl_we_o     = 1'b1;
                    tbl_idx_o    = q_idx_q[head_q];
                    tbl_target_o = q_tgt_q[head_q];
                    tbl_taken_o  = q_taken_q[head_q];
                    tbl_tgt_we_o = q_mispred_q[head_q];
                end
            end else begin
                tbl_we_o     = 1'b1;
                tbl_clr_o    = 1'b1;
                tbl_tgt_we_o = 1'b1;
                tbl_idx_o    = swp_q;
                tbl_target_o = '1;
            end
        end
    end
endmodule

// File: tb/tb_btb_upd_sched.sv
module tb_btb_upd_sched;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        upd_valid_i, upd_ready_o;
    logic [6:0]  upd_idx_i;
    logic [31:0] upd_target_i;
    logic        upd_taken_i, upd_mispred_i, inv_all_i, lookup_req_i, lookup_gnt_o;
    logic        tbl_we_o, tbl_taken_o, tbl_tgt_we_o, tbl_clr_o, busy_o;
    logic [6:0]  tbl_idx_o;
    logic [31:0] tbl_target_o;
    logic [2:0]  q_count_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    btb_upd_sched dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
        .upd_idx_i(upd_idx_i), .upd_target_i(upd_target_i),
        .upd_taken_i(upd_taken_i), .upd_mispred_i(upd_mispred_i),
        .inv_all_i(inv_all_i), .lookup_req_i(lookup_req_i), .lookup_gnt_o(lookup_gnt_o),
        .tbl_we_o(tbl_we_o), .tbl_idx_o(tbl_idx_o), .tbl_target_o(tbl_target_o),
        .tbl_taken_o(tbl_taken_o), .tbl_tgt_we_o(tbl_tgt_we_o), .tbl_clr_o(tbl_clr_o),
        .busy_o(busy_o), .q_count_o(q_count_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] idx, input logic [31:0] tgt,
                         input logic tk, input logic mp);
        upd_valid_i = v; upd_idx_i = idx; upd_target_i = tgt;
        upd_taken_i = tk; upd_mispred_i = mp;
    endtask

    // Walks a full invalidate sweep starting at index 0.
    task automatic sweep_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk(tag, {tbl_we_o, tbl_clr_o, tbl_tgt_we_o, busy_o, lookup_gnt_o, upd_ready_o, tbl_idx_o},
                     {6'b111100, 7'(i)});
            step();
        end
    endtask

    initial begin
        rst_ni = 1'b0; inv_all_i = 1'b0; lookup_req_i = 1'b1;
        drive(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        step(); step(); step();
        #1;
        chk("rst_out", {upd_ready_o, lookup_gnt_o, tbl_we_o, tbl_clr_o, tbl_tgt_we_o, tbl_taken_o},
                       6'b0);
        chk("rst_idx_tgt", {tbl_idx_o, tbl_target_o}, 39'd0);
        chk("rst_busy", busy_o, 1'b1);
        chk("rst_qcnt", q_count_o, 3'd0);

        // Power-up sweep
        rst_ni = 1'b1; lookup_req_i = 1'b0;
        sweep_chk("init_sweep", 128);
        #1;
        chk("run_busy", busy_o, 1'b0);
        chk("run_ready", upd_ready_o, 1'b1);
        chk("run_idle_we", tbl_we_o, 1'b0);

        // Single update drains the next cycle when IF is idle
        drive(1'b1, 7'd5, 32'h40, 1'b1, 1'b1);
        step();
        drive(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("single_wr", {tbl_we_o, tbl_idx_o, tbl_tgt_we_o, tbl_taken_o, tbl_clr_o},
                         {1'b1, 7'd5, 3'b110});
        chk("single_tgt", tbl_target_o, 32'h40);
        chk("single_qc1", q_count_o, 3'd1);
        step(); #1;
        chk("single_qc0", {q_count_o, tbl_we_o}, {3'd0, 1'b0});

        // Push and pop in the same cycle: occupancy holds at 1
        drive(1'b1, 7'd30, 32'h300, 1'b0, 1'b0);
        step();
        drive(1'b1, 7'd31, 32'h310, 1'b0, 1'b0);
        #1;
        chk("pp_pop30", {tbl_we_o, tbl_idx_o}, {1'b1, 7'd30});
        step();
        drive(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("pp_qc", q_count_o, 3'd1);
        chk("pp_pop31", {tbl_we_o, tbl_idx_o}, {1'b1, 7'd31});
        step(); #1;
        chk("pp_empty", q_count_o, 3'd0);

        // Full queue forces a drain against a held lookup
        lookup_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7'(10 + i), 32'(16 * i), 1'b0, 1'b0);
            #1;
            chk("fill_gnt", {lookup_gnt_o, tbl_we_o}, 2'b10);
            step();
        end
        drive(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("full_qc", q_count_o, 3'd4);
        chk("full_ready", upd_ready_o, 1'b0);
        chk("full_drain", {tbl_we_o, tbl_idx_o, lookup_gnt_o}, {1'b1, 7'd10, 1'b0});
        step();
        lookup_req_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("fifo_order", {tbl_we_o, tbl_idx_o}, {1'b1, 7'(10 + i)});
            step();
        end
        #1;
        chk("fifo_empty", q_count_o, 3'd0);

        // Starvation: a held lookup wins for STARVE_MAX cycles only
        lookup_req_i = 1'b1;
        drive(1'b1, 7'd20, 32'h200, 1'b1, 1'b0);
        step();
        drive(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("starve_wait", {lookup_gnt_o, tbl_we_o}, 2'b10);
            step();
        end
        #1;
        chk("starve_drain", {lookup_gnt_o, tbl_we_o, tbl_idx_o}, {1'b0, 1'b1, 7'd20});
        step(); #1;
        chk("starve_after", {lookup_gnt_o, q_count_o}, {1'b1, 3'd0});

        // Merge of back-to-back updates to the same index
        drive(1'b1, 7'd9, 32'h100, 1'b1, 1'b1);
        step();
        drive(1'b1, 7'd9, 32'h200, 1'b0, 1'b0);
        #1;
        chk("merge_ready", upd_ready_o, 1'b1);
        step();
        drive(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("merge_qc", q_count_o, 3'd1);
        lookup_req_i = 1'b0;
        #1;
        chk("merge_wr", {tbl_we_o, tbl_idx_o, tbl_tgt_we_o, tbl_taken_o}, {1'b1, 7'd9, 2'b10});
        chk("merge_tgt", tbl_target_o, 32'h200);
        step(); #1;
        chk("merge_once", {tbl_we_o, q_count_o}, {1'b0, 3'd0});

        // inv_all flushes the queue and starts a clear sweep
        lookup_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'(40 + i), 32'h1000, 1'b1, 1'b1);
            step();
        end
        inv_all_i = 1'b1;
        drive(1'b1, 7'd50, 32'h5000, 1'b1, 1'b1);
        #1;
        chk("inv_ready", upd_ready_o, 1'b0);
        chk("inv_nowr", tbl_we_o, 1'b0);
        step();
        inv_all_i = 1'b0; lookup_req_i = 1'b0;
        drive(1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("clr_qc", q_count_o, 3'd0);
        sweep_chk("clr_sweep", 60);

        // Reset mid-sweep restarts the sweep from index 0
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_we", {tbl_we_o, busy_o}, 2'b01);
        step();
        rst_ni = 1'b1;
        sweep_chk("rst_sweep", 128);
        #1;
        chk("end_busy", busy_o, 1'b0);
        chk("end_flushed", {tbl_we_o, q_count_o, upd_ready_o}, {1'b0, 3'd0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
